// File: rtl/mac_pause_req_ctrl_pkg.sv
// rtl/mac_pause_req_ctrl_pkg.sv - shared types and constants for the pause request controller
package mac_pause_pkg;

    localparam int MAX_CLASS = 8;

    typedef enum logic [1:0] {
        ST_XON       = 2'd0,
        ST_XOFF_HOLD = 2'd1,
        ST_XOFF      = 2'd2
    } pause_state_e;

endpackage

// File: rtl/mac_pause_req_ctrl_if.sv
// rtl/mac_pause_req_ctrl_if.sv - pause request bundle from the controller to the pause transmit block
interface mac_pause_req_if;
    import mac_pause_pkg::*;

    logic                 tx_lfc_req;
    logic [MAX_CLASS-1:0] tx_pfc_req;
    logic                 tx_lfc_resend;
    logic                 tx_pfc_resend;

    modport master (output tx_lfc_req, output tx_pfc_req, output tx_lfc_resend, output tx_pfc_resend);
    modport slave  (input  tx_lfc_req, input  tx_pfc_req, input  tx_lfc_resend, input  tx_pfc_resend);
endinterface

// File: rtl/mac_pause_req_ctrl_class_fsm.sv
// rtl/mac_pause_req_ctrl_class_fsm.sv - one traffic class: XON/XOFF hysteresis, hold counter, crit flag (MAC_PAUSE_REQ_RESEND_EN)
module mac_pause_class_fsm
    import mac_pause_pkg::*;
#(
    parameter int LEVEL_W = 16,
    parameter int HOLD_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_en,
    input  logic [LEVEL_W-1:0] level,
    input  logic [LEVEL_W-1:0] xoff_thresh,
    input  logic [LEVEL_W-1:0] xon_thresh,
    input  logic [LEVEL_W-1:0] crit_thresh,
    input  logic [HOLD_W-1:0]  min_hold,
    input  logic               quanta_tick,
    output logic               paused,
    output logic               xoff_evt,
    output logic               crit_rise
);

    pause_state_e       state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               xoff_evt_q, xoff_evt_d;
    logic               crit_q, crit_d;
    logic               crit_rise_q, crit_rise_d;
    logic [LEVEL_W-1:0] eff_xon;

    // Clamping XON to XOFF keeps a misconfigured pair from oscillating.
    assign eff_xon = (xon_thresh < xoff_thresh) ? xon_thresh : xoff_thresh;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        xoff_evt_d = 1'b0;
        if (!cfg_en) begin
            state_d    = ST_XON;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                ST_XON: begin
                    if (level >= xoff_thresh) begin
                        xoff_evt_d = 1'b1;
                        hold_cnt_d = min_hold;
                        state_d    = (min_hold == '0) ? ST_XOFF : ST_XOFF_HOLD;
                    end
                end
                ST_XOFF_HOLD: begin
                    if (quanta_tick) begin
                        hold_cnt_d = hold_cnt_q - 1'b1;
                        if (hold_cnt_q == HOLD_W'(1)) state_d = ST_XOFF;
                    end
                end
                ST_XOFF: begin
                    if (level < eff_xon) state_d = ST_XON;
                end
                default: begin
                    state_d    = ST_XON;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

`ifdef MAC_PAUSE_REQ_RESEND_EN
    assign crit_d = cfg_en && (state_q != ST_XON) && (level >= crit_thresh);
`else
    logic unused_crit;
    assign unused_crit = ^crit_thresh;
    assign crit_d      = 1'b0;
`endif
    assign crit_rise_d = crit_d && !crit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_XON;
            hold_cnt_q  <= '0;
            xoff_evt_q  <= 1'b0;
            crit_q      <= 1'b0;
            crit_rise_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            xoff_evt_q  <= xoff_evt_d;
            crit_q      <= crit_d;
            crit_rise_q <= crit_rise_d;
        end
    end

    assign paused    = (state_q != ST_XON);
    assign xoff_evt  = xoff_evt_q;
    assign crit_rise = crit_rise_q;

endmodule

// File: rtl/mac_pause_req_ctrl.sv
// rtl/mac_pause_req_ctrl.sv - per-class watermark pause request controller; resend strobes under MAC_PAUSE_REQ_RESEND_EN
module mac_pause_req_ctrl
    import mac_pause_pkg::*;
#(
    parameter int NUM_CLASS = 8,
    parameter int LEVEL_W   = 16,
    parameter int HOLD_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CLASS*LEVEL_W-1:0] rx_level,
    input  logic                         cfg_en,
    input  logic                         cfg_pfc_mode,
    input  logic [NUM_CLASS*LEVEL_W-1:0] cfg_xoff_thresh,
    input  logic [NUM_CLASS*LEVEL_W-1:0] cfg_xon_thresh,
    input  logic [HOLD_W-1:0]            cfg_min_hold,
    input  logic [NUM_CLASS*LEVEL_W-1:0] cfg_crit_thresh,
    input  logic                         cfg_quanta_clk_en,
    mac_pause_req_if.master              req_if,
    output logic [NUM_CLASS-1:0]         stat_class_paused,
    output logic [NUM_CLASS-1:0]         stat_xoff_evt
);

    logic [NUM_CLASS-1:0] paused;
    logic [NUM_CLASS-1:0] xoff_evt;
    logic [NUM_CLASS-1:0] crit_rise;

    for (genvar k = 0; k < NUM_CLASS; k++) begin : g_class
        mac_pause_class_fsm #(
            .LEVEL_W (LEVEL_W),
            .HOLD_W  (HOLD_W)
        ) u_fsm (
            .clk         (clk),
            .rst         (rst),
            .cfg_en      (cfg_en),
            .level       (rx_level[k*LEVEL_W +: LEVEL_W]),
            .xoff_thresh (cfg_xoff_thresh[k*LEVEL_W +: LEVEL_W]),
            .xon_thresh  (cfg_xon_thresh[k*LEVEL_W +: LEVEL_W]),
            .crit_thresh (cfg_crit_thresh[k*LEVEL_W +: LEVEL_W]),
            .min_hold    (cfg_min_hold),
            .quanta_tick (cfg_quanta_clk_en),
            .paused      (paused[k]),
            .xoff_evt    (xoff_evt[k]),
            .crit_rise   (crit_rise[k])
        );
    end

    logic                 lfc_req_q, lfc_req_d;
    logic [MAX_CLASS-1:0] pfc_req_q, pfc_req_d;
    logic                 lfc_resend_q, lfc_resend_d;
    logic                 pfc_resend_q, pfc_resend_d;
    logic [NUM_CLASS-1:0] class_paused_q, class_paused_d;
    logic [NUM_CLASS-1:0] xoff_evt_q, xoff_evt_d;

    // Mode only re-maps outputs; class state is untouched by a mode change.
    always_comb begin
        pfc_req_d = '0;
        if (cfg_pfc_mode) pfc_req_d[NUM_CLASS-1:0] = paused;
        lfc_req_d      = !cfg_pfc_mode && (|paused);
        pfc_resend_d   = cfg_pfc_mode && (|crit_rise);
        lfc_resend_d   = !cfg_pfc_mode && (|crit_rise);
        class_paused_d = paused;
        xoff_evt_d     = xoff_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfc_req_q      <= 1'b0;
            pfc_req_q      <= '0;
            lfc_resend_q   <= 1'b0;
            pfc_resend_q   <= 1'b0;
            class_paused_q <= '0;
            xoff_evt_q     <= '0;
        end else begin
            lfc_req_q      <= lfc_req_d;
            pfc_req_q      <= pfc_req_d;
            lfc_resend_q   <= lfc_resend_d;
            pfc_resend_q   <= pfc_resend_d;
            class_paused_q <= class_paused_d;
            xoff_evt_q     <= xoff_evt_d;
        end
    end

    assign req_if.tx_lfc_req    = lfc_req_q;
    assign req_if.tx_pfc_req    = pfc_req_q;
    assign req_if.tx_lfc_resend = lfc_resend_q;
    assign req_if.tx_pfc_resend = pfc_resend_q;
    assign stat_class_paused    = class_paused_q;
    assign stat_xoff_evt        = xoff_evt_q;

endmodule

// File: doc/mac_pause_req_ctrl.md
Name: mac_pause_req_ctrl

Overview:
- Per-class watermark controller that turns RX buffer fill levels into the tx_lfc_req / tx_pfc_req levels consumed by the pause/PFC transmit block.
- Applies XOFF/XON hysteresis and a minimum XOFF hold time counted in pause quanta.
- Selects link-level or priority flow-control output mode.
- Sits between the RX packet FIFOs and the MAC pause transmit logic.

Parameters:
NUM_CLASS, 8, number of traffic classes (1..8); unused PFC bits are driven 0
LEVEL_W, 16, width of each fill-level and threshold field
HOLD_W, 16, width of the minimum-hold quanta counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rx_level  in  NUM_CLASS*LEVEL_W  per-class buffer fill level, class k at [k*LEVEL_W +: LEVEL_W]
cfg_en  in  1  controller enable
cfg_pfc_mode  in  1  1: per-class PFC requests; 0: single LFC request
cfg_xoff_thresh  in  NUM_CLASS*LEVEL_W  per-class XOFF watermark
cfg_xon_thresh  in  NUM_CLASS*LEVEL_W  per-class XON watermark
cfg_min_hold  in  HOLD_W  minimum XOFF duration, in quanta ticks
cfg_crit_thresh  in  NUM_CLASS*LEVEL_W  per-class critical watermark (optional feature only)
cfg_quanta_clk_en  in  1  one-cycle quanta tick strobe
tx_lfc_req  out  1  LFC pause request level
tx_pfc_req  out  8  PFC pause request levels
tx_lfc_resend  out  1  LFC resend strobe
tx_pfc_resend  out  1  PFC resend strobe
stat_class_paused  out  NUM_CLASS  per-class state != XON
stat_xoff_evt  out  NUM_CLASS  one-cycle pulse on XON->XOFF_HOLD entry

Behaviour:
Reset:
- Every class state goes to XON and every hold counter to 0.
- All outputs reset to 0.

Per-class FSM. States: XON, XOFF_HOLD, XOFF.
- XON -> XOFF_HOLD when cfg_en && level >= xoff_thresh. Load hold_cnt = cfg_min_hold and pulse stat_xoff_evt[k].
- If cfg_min_hold == 0, go XON -> XOFF directly; stat_xoff_evt still pulses.
- XOFF_HOLD: hold_cnt decrements by 1 on each cfg_quanta_clk_en. When hold_cnt == 1 and a tick arrives, -> XOFF. Level is ignored in this state.
- XOFF -> XON when level < eff_xon, where eff_xon = min(xon_thresh, xoff_thresh). A misconfigured xon > xoff therefore cannot oscillate.
- All comparisons are unsigned at LEVEL_W bits.

Request outputs:
- paused[k] = (state_k != XON). stat_class_paused = paused.
- tx_pfc_req = cfg_pfc_mode ? paused (zero-extended to 8 bits) : 0.
- tx_lfc_req = !cfg_pfc_mode && |paused.
- Outputs are registered. A level crossing sampled at edge n is visible on the outputs after edge n+1 (1-cycle latency).

Boundary and simultaneous conditions:
- cfg_en low: all classes forced to XON on the next edge and counters cleared, regardless of state. Requests drop the following cycle.
- A mode change mid-pause only re-maps the outputs; FSM state is kept.
- A quanta tick in the same cycle as XON->XOFF_HOLD entry does not decrement; the counter loads cfg_min_hold.
- Classes are fully independent; any number may transition in the same cycle.
- Reset mid-hold aborts immediately, and requests return to 0.

Optional Feature:
Macro MAC_PAUSE_REQ_RESEND_EN.
- Defined: each class keeps a registered flag crit_k = (level >= crit_thresh) && state != XON. A 0->1 transition of any crit_k pulses for one cycle:
  - tx_pfc_resend when cfg_pfc_mode = 1;
  - tx_lfc_resend when cfg_pfc_mode = 0.
- The pulse forces an immediate refresh frame when a buffer keeps filling during pause.
- crit_k clears on return to XON.
- Not defined: tx_lfc_resend = tx_pfc_resend = 0 and cfg_crit_thresh is unused.

Decomposition:
- Shared package mac_pause_pkg holds:
  - state enum {XON, XOFF_HOLD, XOFF} as a 2-bit encoding;
  - constant MAX_CLASS = 8.
- One natural sub-module: mac_pause_class_fsm (one class: FSM, hold counter, crit flag), instantiated NUM_CLASS times by a generate loop.
- The top level holds output mapping and registering.

Test Plan:
1. PFC mode, class 3, xoff = 100, xon = 40, min_hold = 0. rx_level[3] goes 99 -> 100 -> tx_pfc_req = 8'h08 one cycle later and stat_xoff_evt[3] pulses. Level 40 keeps the request; level 39 -> tx_pfc_req = 0.
2. min_hold = 3, class 0 enters XOFF_HOLD, level dropped to 0 immediately -> request held until the 3rd quanta tick, then drops the next cycle.
3. LFC mode, classes 1 and 5 paused -> tx_lfc_req = 1 and tx_pfc_req = 0. Class 1 clears -> still 1. Class 5 clears -> 0.
4. cfg_en deasserted while 4 classes are in XOFF_HOLD/XOFF -> all requests 0 within 2 cycles and stat_class_paused = 0.
5. xon = 200, xoff = 100 (misconfigured), level steady at 150 -> class stays paused, no toggling over 1000 cycles.
6. MAC_PAUSE_REQ_RESEND_EN defined, crit = 180, paused class 2 level goes 170 -> 185 -> exactly one cycle of tx_pfc_resend. Level 190 -> no further pulse.
